// File: rtl/nn_pkg.sv
// Shared constants and state encoding for the neural-network datapath stages.
package nn_pkg;

  localparam int SUM_W  = 20;
  localparam int ACT_W  = 8;
  localparam int BIAS_W = 16;

  typedef enum logic [1:0] {
    ACCUM,
    FINAL,
    OUT
  } accum_state_t;

endpackage

// File: rtl/act_quant.sv
// Combinational requantiser: bias add, round-to-nearest, arithmetic shift,
// ReLU and saturation to an unsigned 8-bit activation.
module act_quant
  import nn_pkg::*;
#(
  parameter int ACC_W     = 24,
  parameter int OUT_SHIFT = 8
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [BIAS_W-1:0] bias_i,
  output logic [ACT_W-1:0]  act_o
);

  localparam int EXT_W = ACC_W + 1;
  localparam logic [EXT_W-1:0] ROUND = EXT_W'(1) << (OUT_SHIFT - 1);

  logic signed [EXT_W-1:0] accExt;
  logic signed [EXT_W-1:0] biasExt;
  logic signed [EXT_W-1:0] total;
  logic signed [EXT_W-1:0] shifted;

  // One extra bit of headroom keeps the bias and rounding additions from wrapping.
  always_comb begin
    accExt  = {acc_i[ACC_W-1], acc_i};
    biasExt = {{(EXT_W-BIAS_W){bias_i[BIAS_W-1]}}, bias_i};
    total   = accExt + biasExt + $signed(ROUND);
    shifted = total >>> OUT_SHIFT;
    if (shifted[EXT_W-1]) begin
      act_o = '0;
    end else if (|shifted[EXT_W-2:ACT_W]) begin
      act_o = '1;
    end else begin
      act_o = shifted[ACT_W-1:0];
    end
  end

endmodule

// File: rtl/neuron_accum.sv
// Accumulates NUM_CHUNKS partial sums per neuron, requantises the result and
// offers the activation on a valid/ready output.
module neuron_accum
  import nn_pkg::*;
#(
  parameter int NUM_CHUNKS = 4,
  parameter int ACC_W      = 24,
  parameter int OUT_SHIFT  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SUM_W-1:0]  sum_in,
  input  logic              sum_valid,
  output logic              in_ready,
  input  logic [BIAS_W-1:0] bias_in,
  output logic [ACT_W-1:0]  act_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun
);

  localparam int CNT_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNKS - 1);

  accum_state_t     state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACT_W-1:0] actOut_q, actOut_d;
  logic             outValid_q, outValid_d;
  logic             overrun_q, overrun_d;
  logic [ACC_W-1:0] sumExt;
  logic [ACT_W-1:0] quantAct;

  assign sumExt    = {{(ACC_W-SUM_W){sum_in[SUM_W-1]}}, sum_in};
  assign in_ready  = (state_q == ACCUM);
  assign act_out   = actOut_q;
  assign out_valid = outValid_q;
  assign overrun   = overrun_q;

  act_quant #(
    .ACC_W    (ACC_W),
    .OUT_SHIFT(OUT_SHIFT)
  ) u_quant (
    .acc_i (acc_q),
    .bias_i(bias_in),
    .act_o (quantAct)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ACCUM;
      acc_q      <= '0;
      cnt_q      <= '0;
      actOut_q   <= '0;
      outValid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      actOut_q   <= actOut_d;
      outValid_q <= outValid_d;
      overrun_q  <= overrun_d;
    end
  end

  // Samples arriving outside ACCUM are dropped and only raise the sticky overrun flag.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    actOut_d   = actOut_q;
    outValid_d = outValid_q;
    overrun_d  = overrun_q | (sum_valid & ~in_ready);
    case (state_q)
      ACCUM: begin
        if (sum_valid) begin
          acc_d = acc_q + sumExt;
          if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            state_d = FINAL;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      FINAL: begin
        actOut_d   = quantAct;
        outValid_d = 1'b1;
        acc_d      = '0;
        state_d    = OUT;
      end
      OUT: begin
        if (out_ready) begin
          outValid_d = 1'b0;
          state_d    = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

endmodule

// File: tb/tb_neuron_accum.sv
// Directed self-checking bench for neuron_accum at default parameters.
module tb_neuron_accum;

  logic        clk;
  logic        rst;
  logic [19:0] sum_in;
  logic        sum_valid;
  logic        in_ready;
  logic [15:0] bias_in;
  logic [7:0]  act_out;
  logic        out_valid;
  logic        out_ready;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  neuron_accum dut (
    .clk      (clk),
    .rst      (rst),
    .sum_in   (sum_in),
    .sum_valid(sum_valid),
    .in_ready (in_ready),
    .bias_in  (bias_in),
    .act_out  (act_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Presents one chunk for a single edge, then idles the input.
  task automatic applyStimulus(input int value);
    sum_in    = 20'(value);
    sum_valid = 1'b1;
    tick();
    sum_valid = 1'b0;
    sum_in    = 20'h0;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_act_out"}, 32'(act_out), 32'd0);
    checkOutput({tag, "_overrun"}, 32'(overrun), 32'd0);
  endtask

  // Four back-to-back chunks, then FINAL, one OUT cycle and the handshake.
  task automatic runNeuron(input string tag, input int c0, input int c1, input int c2, input int c3,
                           input int bias, input int expAct);
    bias_in   = 16'(bias);
    out_ready = 1'b1;
    applyStimulus(c0);
    applyStimulus(c1);
    applyStimulus(c2);
    applyStimulus(c3);
    checkOutput({tag, "_final_in_ready"}, 32'(in_ready), 32'd0);
    checkOutput({tag, "_final_out_valid"}, 32'(out_valid), 32'd0);
    tick();
    checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, "_act_out"}, 32'(act_out), 32'(expAct));
    tick();
    checkOutput({tag, "_done_out_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_done_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    sum_in    = 20'h0;
    sum_valid = 1'b0;
    bias_in   = 16'h0;
    out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checkReset("reset");

    runNeuron("n4300x4", 4300, 4300, 4300, 4300, 0, 67);
    runNeuron("mixed", 4300, 936, 1558, 0, 0, 27);
    runNeuron("relu", -4300, -4300, -4300, -4300, 0, 0);
    runNeuron("saturate", 'h7FFFF, 'h7FFFF, 'h7FFFF, 'h7FFFF, 0, 255);
    runNeuron("round_b128", 0, 0, 0, 0, 128, 1);
    runNeuron("round_b127", 0, 0, 0, 0, 127, 0);
    runNeuron("round_bneg", 0, 0, 0, 0, -1000, 0);
    checkOutput("overrun_clean", 32'(overrun), 32'd0);

    // Backpressure with a stray sample while the output is held.
    bias_in   = 16'h0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(4300);
    tick();
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_act_out", 32'(act_out), 32'd67);
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
      if (i == 2) applyStimulus(100000);
      else tick();
    end
    checkOutput("bp_overrun", 32'(overrun), 32'd1);
    checkOutput("bp_held_act", 32'(act_out), 32'd67);
    out_ready = 1'b1;
    tick();
    checkOutput("bp_release_out_valid", 32'(out_valid), 32'd0);
    checkOutput("bp_release_in_ready", 32'(in_ready), 32'd1);
    runNeuron("after_drop", 4300, 936, 1558, 0, 0, 27);
    checkOutput("overrun_sticky", 32'(overrun), 32'd1);

    // Gapped input: the count must advance only on valid cycles.
    for (int i = 0; i < 7; i++) begin
      sum_in    = 20'd1;
      sum_valid = (i % 2 == 0);
      tick();
      if (i == 5) checkOutput("gap_three_chunks_in_ready", 32'(in_ready), 32'd1);
    end
    sum_valid = 1'b0;
    checkOutput("gap_final_in_ready", 32'(in_ready), 32'd0);
    tick();
    checkOutput("gap_out_valid", 32'(out_valid), 32'd1);
    checkOutput("gap_act_out", 32'(act_out), 32'd0);
    tick();
    checkOutput("gap_done_in_ready", 32'(in_ready), 32'd1);

    // Reset mid-accumulation discards the partial neuron.
    applyStimulus(4300);
    applyStimulus(4300);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkReset("midreset");
    runNeuron("post_reset", 4300, 4300, 4300, 4300, 0, 67);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
